// File: rtl/ram_fifo_if.sv
// Handshake bundle for ram_fifo: write side, read side and status flags.
// The master modport is the user of the FIFO; the slave modport is the FIFO itself.
interface ram_fifo_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
);
    logic                     wr_en;
    logic [WIDTH-1:0]         wr_data;
    logic                     full;
    logic                     almost_full;
    logic                     rd_en;
    logic [WIDTH-1:0]         rd_data;
    logic                     rd_valid;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  full, almost_full, rd_data, rd_valid, empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, almost_full, rd_data, rd_valid, empty, count, overflow, underflow
    );
endinterface

// File: rtl/ram_fifo.sv
// Synchronous FIFO on a DEPTH x WIDTH block-RAM-style array with registered read.
// Define RAM_FIFO_FWFT_EN for first-word-fall-through mode: the head word is prefetched
// through the RAM output register into an output register so it is visible before rd_en.
// Default build (macro undefined) is the standard mode: rd_en returns the word one cycle later.
module ram_fifo #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AFULL_LEVEL = DEPTH - 2
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_fifo_if.slave    bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
    localparam logic [CW-1:0] AfullCnt = CW'(AFULL_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q, afull_q;
    logic             empty_d;
    logic             overflow_q, underflow_q;
    logic             underflow_d;
    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q;

    // wr_acc: word enters storage; rd_acc: word leaves the FIFO (count decrement);
    // rd_fetch: RAM read pointer advances (same as rd_acc in standard mode).
    logic wr_acc, rd_acc, rd_fetch;

    assign wr_acc = bus.wr_en && !full_q;

    // Array write; no reset so the storage can map onto block RAM.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

`ifdef RAM_FIFO_FWFT_EN
    logic [WIDTH-1:0] ram_q;
    logic             ram_valid_q, ram_valid_d;
    logic [CW-1:0]    mem_cnt_q, mem_cnt_d;
    logic             rd_valid_d;
    logic             out_free;

    assign rd_acc   = bus.rd_en && rd_valid_q;
    // Output register can take a new word if it is empty or being popped this edge.
    assign out_free = !rd_valid_q || rd_acc;
    // Fetch from RAM whenever it holds words and the RAM output stage will be free.
    assign rd_fetch = (mem_cnt_q != '0) && (!ram_valid_q || out_free);

    // Prefetch pipeline bookkeeping: RAM output stage, output register, words left in RAM.
    always_comb begin
        ram_valid_d = rd_fetch || (ram_valid_q && !out_free);
        rd_valid_d  = out_free ? ram_valid_q : 1'b1;
        mem_cnt_d   = mem_cnt_q;
        if (wr_acc && !rd_fetch) begin
            mem_cnt_d = mem_cnt_q + 1'b1;
        end else if (!wr_acc && rd_fetch) begin
            mem_cnt_d = mem_cnt_q - 1'b1;
        end
        empty_d     = !rd_valid_d;
        underflow_d = bus.rd_en && !rd_valid_q;
    end

    // Registered RAM read into the intermediate stage; contents only matter when valid.
    always_ff @(posedge clk) begin
        if (rd_fetch) begin
            ram_q <= mem[rd_ptr_q];
        end
    end

    // Output register and prefetch state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_valid_q <= 1'b0;
            mem_cnt_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            ram_valid_q <= ram_valid_d;
            mem_cnt_q   <= mem_cnt_d;
            rd_valid_q  <= rd_valid_d;
            if (out_free && ram_valid_q) begin
                rd_data_q <= ram_q;
            end
        end
    end
`else
    assign rd_acc   = bus.rd_en && !empty_q;
    assign rd_fetch = rd_acc;

    // Standard mode needs no extra pipeline state.
    always_comb begin
        empty_d     = (count_d == '0);
        underflow_d = bus.rd_en && empty_q;
    end

    // Registered read: the word is valid for exactly the cycle after an accepted read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem[rd_ptr_q];
            end
        end
    end
`endif

    // Next pointers and occupancy; flags derive from the post-edge count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_fetch) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            2'b00,
            2'b11:   count_d = count_q;
            default: count_d = count_q;
        endcase
    end

    // Pointers, count and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == DepthCnt);
            empty_q     <= empty_d;
            afull_q     <= (count_d >= AfullCnt);
            overflow_q  <= bus.wr_en && full_q;
            underflow_q <= underflow_d;
        end
    end

    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.almost_full = afull_q;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
endmodule

// File: tb/tb_ram_fifo.sv
// Self-checking bench for ram_fifo (WIDTH=8, DEPTH=8, AFULL_LEVEL=6).
// A queue-based model predicts every output each cycle; directed phases add literal checks.
module tb_ram_fifo;
    localparam int unsigned W  = 8;
    localparam int unsigned D  = 8;
    localparam int unsigned AF = 6;

    logic clk;
    logic rst_n;

    ram_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

    ram_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_LEVEL(AF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] d;
        int         t;
    } ent_t;

    ent_t       q[$];
    int         ecnt = 0;
    bit         started = 1'b0;
    logic       m_rd_valid = 1'b0;
    logic [7:0] m_rd_data = 8'h00;
    logic       m_over = 1'b0;
    logic       m_under = 1'b0;

    always @(posedge clk) begin
        bit   full_pre, avail, wacc, racc;
        ent_t e;
        ecnt++;
        started = 1'b1;
        if (!rst_n) begin
            q.delete();
            m_rd_valid = 1'b0;
            m_rd_data  = 8'h00;
            m_over     = 1'b0;
            m_under    = 1'b0;
        end else begin
            full_pre = (q.size() == D);
`ifdef RAM_FIFO_FWFT_EN
            avail = m_rd_valid;
`else
            avail = (q.size() > 0);
`endif
            wacc    = bus.wr_en && !full_pre;
            racc    = bus.rd_en && avail;
            m_over  = bus.wr_en && full_pre;
            m_under = bus.rd_en && !avail;
            if (racc) begin
                e = q.pop_front();
`ifndef RAM_FIFO_FWFT_EN
                m_rd_data = e.d;
`endif
            end
            if (wacc) begin
                e.d = bus.wr_data;
                e.t = ecnt;
                q.push_back(e);
            end
`ifdef RAM_FIFO_FWFT_EN
            // Head becomes visible two edges after the edge that wrote it.
            m_rd_valid = (q.size() > 0) && (q[0].t + 2 <= ecnt);
            if (m_rd_valid) m_rd_data = q[0].d;
`else
            m_rd_valid = racc;
`endif
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            int sz;
            sz = q.size();
            chk("count", 32'(bus.count), 32'(sz));
            chk("full", 32'(bus.full), 32'(sz == D));
            chk("almost_full", 32'(bus.almost_full), 32'(sz >= AF));
`ifdef RAM_FIFO_FWFT_EN
            chk("empty", 32'(bus.empty), 32'(!m_rd_valid));
`else
            chk("empty", 32'(bus.empty), 32'(sz == 0));
`endif
            chk("rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
            chk("rd_data", 32'(bus.rd_data), 32'(m_rd_data));
            chk("overflow", 32'(bus.overflow), 32'(m_over));
            chk("underflow", 32'(bus.underflow), 32'(m_under));
        end
    end

    // ---------------- stimulus ----------------
    // Apply inputs, let one rising edge consume them, return 1 time unit after that edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.rd_en   = 1'b0;
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 0);
        rst_n = 1'b1;
        cyc(0, 8'h00, 0);

        // Reset/idle state pinned with literals.
        chk("lit_reset_empty", 32'(bus.empty), 32'd1);
        chk("lit_reset_full", 32'(bus.full), 32'd0);
        chk("lit_reset_count", 32'(bus.count), 32'd0);
        chk("lit_reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("lit_reset_rd_data", 32'(bus.rd_data), 32'h00);

        // Fill with 0x11..0x18, then one rejected write.
        for (int i = 0; i < 8; i++) begin
            cyc(1, 8'(8'h11 + i), 0);
            chk("lit_fill_count", 32'(bus.count), 32'(i + 1));
            chk("lit_fill_afull", 32'(bus.almost_full), 32'(i + 1 >= 6));
        end
        cyc(1, 8'h99, 0);
        chk("lit_ovf_pulse", 32'(bus.overflow), 32'd1);
        chk("lit_ovf_full", 32'(bus.full), 32'd1);
        chk("lit_ovf_count", 32'(bus.count), 32'd8);
        cyc(0, 8'h00, 0);
        chk("lit_ovf_once", 32'(bus.overflow), 32'd0);

        // Drain in order, then one read too many.
        for (int i = 0; i < 8; i++) begin
`ifdef RAM_FIFO_FWFT_EN
            chk("lit_drain_head", 32'(bus.rd_data), 32'(8'h11 + i));
            cyc(0, 8'h00, 1);
`else
            cyc(0, 8'h00, 1);
            chk("lit_drain_valid", 32'(bus.rd_valid), 32'd1);
            chk("lit_drain_data", 32'(bus.rd_data), 32'(8'h11 + i));
`endif
        end
        cyc(0, 8'h00, 1);
        chk("lit_udf_pulse", 32'(bus.underflow), 32'd1);
        chk("lit_udf_empty", 32'(bus.empty), 32'd1);
        cyc(0, 8'h00, 0);

        // Single word latency through an empty FIFO.
        cyc(1, 8'hA5, 0);
`ifdef RAM_FIFO_FWFT_EN
        chk("lit_fwft_n", 32'(bus.rd_valid), 32'd0);
        cyc(0, 8'h00, 0);
        chk("lit_fwft_n1", 32'(bus.rd_valid), 32'd0);
        cyc(0, 8'h00, 0);
        chk("lit_fwft_n2_valid", 32'(bus.rd_valid), 32'd1);
        chk("lit_fwft_n2_data", 32'(bus.rd_data), 32'hA5);
        cyc(0, 8'h00, 1);
`else
        cyc(0, 8'h00, 1);
        chk("lit_a5_valid", 32'(bus.rd_valid), 32'd1);
        chk("lit_a5_data", 32'(bus.rd_data), 32'hA5);
`endif
        chk("lit_a5_empty", 32'(bus.empty), 32'd1);

        // Stream 20 words at count 4 with simultaneous write/read across the wrap.
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h20 + i), 0);
        repeat (3) cyc(0, 8'h00, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 8'(8'h24 + i), 1);
            chk("lit_stream_count", 32'(bus.count), 32'd4);
        end
        repeat (8) cyc(0, 8'h00, 1);

        // Reset with 5 words stored, requests asserted during reset.
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h31 + i), 0);
        chk("lit_pre_rst_count", 32'(bus.count), 32'd5);
        rst_n = 1'b0;
        cyc(1, 8'h77, 1);
        rst_n = 1'b1;
        chk("lit_rst_count", 32'(bus.count), 32'd0);
        chk("lit_rst_empty", 32'(bus.empty), 32'd1);
        chk("lit_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("lit_rst_rd_data", 32'(bus.rd_data), 32'h00);
        cyc(0, 8'h00, 1);
        chk("lit_rst_nothing_left", 32'(bus.underflow), 32'd1);

        // Randomized traffic with phases biased toward full and toward empty.
        for (int i = 0; i < 3000; i++) begin
            int unsigned pw, pr;
            unique case ((i / 250) % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 30; pr = 80; end
                default: begin pw = 60; pr = 60; end
            endcase
            rst_n = ($urandom_range(0, 199) != 0);
            cyc(($urandom_range(0, 99) < pw), 8'($urandom), ($urandom_range(0, 99) < pr));
        end
        rst_n = 1'b1;
        cyc(0, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
